// File: rtl/display_pkg.sv
// Shared types and helpers for the front-panel display blocks.
package display_pkg;

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  // Active-low segments: all ones is dark. Slice to the segment width in use.
  localparam int SEG_W_MAX = 64;
  localparam logic [SEG_W_MAX-1:0] SEG_BLANK = '1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_page_scheduler_button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability timer, press pulse.
module button_debounce
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_evt
);

  localparam int CNT_W = idx_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_evt;

  // Down-counter reloads whenever the sample agrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= CNT_LOAD;
      r_evt   <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_evt   <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync2;
        r_cnt   <= CNT_LOAD;
        r_evt   <= r_sync2;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/display_page_scheduler.sv
// Seven-segment page selector: button / auto-rotate advance, skips disabled
// pages, blanks the panel between pages.
//   state    | meaning
//   ST_SHOW  | drive selected page, run dwell timer, accept advances
//   ST_BLANK | panel dark for BLANK_CYCLES after a page change
module display_page_scheduler
  import display_pkg::*;
#(
  parameter int NUM_PAGES       = 2,
  parameter int NUM_DIGIT_PAIRS = 4,
  parameter int SEG_W           = 14,
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int BLANK_CYCLES    = 5_000_000
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      page_btn,
  input  logic                                      auto_mode,
  input  logic [NUM_PAGES-1:0]                      page_en,
  input  logic [NUM_PAGES*NUM_DIGIT_PAIRS*SEG_W-1:0] page_data,
  output logic [NUM_DIGIT_PAIRS*SEG_W-1:0]          led_out,
  output logic [idx_width(NUM_PAGES)-1:0]           page_idx,
  output logic                                      page_change
);

  localparam int PAGE_W     = NUM_DIGIT_PAIRS * SEG_W;
  localparam int IDX_W      = idx_width(NUM_PAGES);
  localparam int DWELL_W    = idx_width(DWELL_CYCLES);
  localparam int BLANK_W    = idx_width((BLANK_CYCLES > 0) ? BLANK_CYCLES : 1);
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam logic [PAGE_W-1:0] LED_BLANK = {NUM_DIGIT_PAIRS{SEG_BLANK[SEG_W-1:0]}};

  state_e               r_state;
  logic [PAGE_W-1:0]    r_led;
  logic [IDX_W-1:0]     r_page_idx;
  logic                 r_page_change;
  logic [DWELL_W-1:0]   r_dwell;
  logic [BLANK_W-1:0]   r_blank;

  logic                 w_btn_evt;
  logic                 w_any_en;
  logic                 w_cur_dis;
  logic                 w_dwell_exp;
  logic                 w_advance;
  logic [IDX_W-1:0]     w_next_page;
  logic [PAGE_W-1:0]    w_pages [NUM_PAGES];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .i_btn(page_btn),
    .o_evt(w_btn_evt)
  );

  for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page
    assign w_pages[p] = page_data[p*PAGE_W +: PAGE_W];
  end

  // Pick the enabled page at the smallest forward distance; the current
  // page sits at distance NUM_PAGES so it is never chosen over another.
  always_comb begin
    int v_best;
    int v_dist;
    w_next_page = r_page_idx;
    v_best      = NUM_PAGES;
    v_dist      = 0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      v_dist = (p > int'(r_page_idx)) ? p - int'(r_page_idx)
                                      : p + NUM_PAGES - int'(r_page_idx);
      if (page_en[p] && (v_dist < v_best)) begin
        v_best      = v_dist;
        w_next_page = IDX_W'(p);
      end
    end
  end

  assign w_any_en    = |page_en;
  assign w_cur_dis   = !page_en[r_page_idx];
  assign w_dwell_exp = auto_mode && (r_dwell == DWELL_W'(DWELL_CYCLES - 1));
  assign w_advance   = w_any_en && (w_btn_evt || w_dwell_exp || w_cur_dis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_SHOW;
      r_led         <= LED_BLANK;
      r_page_idx    <= '0;
      r_page_change <= 1'b0;
      r_dwell       <= '0;
      r_blank       <= '0;
    end else begin
      r_page_change <= 1'b0;
      case (r_state)
        ST_SHOW: begin
          r_led <= w_any_en ? w_pages[r_page_idx] : LED_BLANK;
          if (w_advance && (w_next_page != r_page_idx)) begin
            r_page_idx    <= w_next_page;
            r_page_change <= 1'b1;
            r_dwell       <= '0;
            if (BLANK_CYCLES > 0) begin
              r_state <= ST_BLANK;
              r_blank <= '0;
            end
          end else if (w_advance || w_dwell_exp || !auto_mode) begin
            r_dwell <= '0;
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        ST_BLANK: begin
          r_led   <= LED_BLANK;
          r_dwell <= '0;
          if (r_blank == BLANK_W'(BLANK_LAST)) begin
            r_state <= ST_SHOW;
            r_blank <= '0;
          end else begin
            r_blank <= r_blank + 1'b1;
          end
        end
        default: r_state <= ST_SHOW;
      endcase
    end
  end

  assign led_out     = r_led;
  assign page_idx    = r_page_idx;
  assign page_change = r_page_change;

endmodule

// File: tb/tb_display_page_scheduler.sv
// Self-checking bench for display_page_scheduler: vector table plus
// scoreboarded page-change sequences.
module tb_display_page_scheduler;

  localparam int NP = 3;
  localparam int NDP = 4;
  localparam int SW = 14;
  localparam int LW = NDP * SW;
  localparam logic [LW-1:0] ALL_OFF = '1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              page_btn = 1'b0;
  logic              auto_mode = 1'b0;
  logic [NP-1:0]     page_en = '0;
  logic [NP*LW-1:0]  page_data = '0;
  logic [LW-1:0]     led_out;
  logic [1:0]        page_idx;
  logic              page_change;

  display_page_scheduler #(
    .NUM_PAGES      (NP),
    .NUM_DIGIT_PAIRS(NDP),
    .SEG_W          (SW),
    .DWELL_CYCLES   (10),
    .DEBOUNCE_CYCLES(4),
    .BLANK_CYCLES   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .page_btn   (page_btn),
    .auto_mode  (auto_mode),
    .page_en    (page_en),
    .page_data  (page_data),
    .led_out    (led_out),
    .page_idx   (page_idx),
    .page_change(page_change)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_pc = 0;
  int cyc = 0;
  int exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] build_led(input logic [SW-1:0] w, input logic [SW-1:0] kx);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < NDP; k++) r[k*SW +: SW] = w ^ SW'(kx * k);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic set_pages(input logic [SW-1:0] w0, input logic [SW-1:0] w1,
                           input logic [SW-1:0] w2, input logic [SW-1:0] kx);
    page_data = {build_led(w2, kx), build_led(w1, kx), build_led(w0, kx)};
  endtask

  task automatic wait_change(input int max_cyc, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (page_change) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  // Scoreboard: every page_change pulse must match the next expected page.
  always @(negedge clk) begin
    if (rst_n && page_change) begin
      n_pc++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_pulse: got page_idx %0d, expected no pulse", page_idx);
      end else begin
        check("sb_page_idx", 64'(page_idx), 64'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic [NP-1:0] en;
    logic [SW-1:0] w0, w1, w2, kx;
    logic [LW-1:0] exp_led;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [LW-1:0] p0, p1;
    int pc0, t_prev, t_now;
    bit blank_seen;

    tbl[0] = '{3'b111, 14'h0001, 14'h0002, 14'h0004, 14'h0000, build_led(14'h0001, 14'h0000)};
    tbl[1] = '{3'b111, 14'h1555, 14'h2aaa, 14'h0f0f, 14'h0400, build_led(14'h1555, 14'h0400)};
    tbl[2] = '{3'b101, 14'h0aaa, 14'h3333, 14'h1111, 14'h0400, build_led(14'h0aaa, 14'h0400)};
    tbl[3] = '{3'b000, 14'h0123, 14'h0456, 14'h0789, 14'h0400, ALL_OFF};
    tbl[4] = '{3'b001, 14'h3c3c, 14'h0001, 14'h0002, 14'h0400, build_led(14'h3c3c, 14'h0400)};
    tbl[5] = '{3'b111, 14'h0000, 14'h3fff, 14'h3fff, 14'h0000, build_led(14'h0000, 14'h0000)};

    // Reset state
    page_en = tbl[0].en;
    set_pages(tbl[0].w0, tbl[0].w1, tbl[0].w2, tbl[0].kx);
    repeat (3) @(negedge clk);
    check("rst_led", led_out, ALL_OFF);
    check("rst_idx", 64'(page_idx), 64'd0);
    check("rst_pc", 64'(page_change), 64'd0);

    // Vector table: live page data and enable masks at page 0
    for (int i = 0; i < 6; i++) begin
      rst_n   = 1'b1;
      page_en = tbl[i].en;
      set_pages(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].kx);
      @(negedge clk);
      check($sformatf("vec%0d_led", i), led_out, tbl[i].exp_led);
      check($sformatf("vec%0d_idx", i), 64'(page_idx), 64'd0);
      check($sformatf("vec%0d_pc", i), 64'(page_change), 64'd0);
    end

    // Glitch rejection, then a real press with blanking
    set_pages(14'h0111, 14'h0222, 14'h0333, 14'h0800);
    p0 = build_led(14'h0111, 14'h0800);
    p1 = build_led(14'h0222, 14'h0800);
    page_en = 3'b111;
    pc0 = n_pc;
    page_btn = 1'b1;
    repeat (3) @(negedge clk);
    page_btn = 1'b0;
    repeat (12) @(negedge clk);
    check("t2_glitch_pulses", 64'(n_pc - pc0), 64'd0);
    check("t2_glitch_idx", 64'(page_idx), 64'd0);
    exp_q.push_back(1);
    fork
      begin
        page_btn = 1'b1;
        repeat (10) @(negedge clk);
        page_btn = 1'b0;
      end
      begin
        wait_change(20, "t2_pulse");
        check("t2_led_at_pulse", led_out, p0);
        @(negedge clk); check("t2_blank0", led_out, ALL_OFF);
        @(negedge clk); check("t2_blank1", led_out, ALL_OFF);
        @(negedge clk); check("t2_page1", led_out, p1);
      end
    join
    repeat (12) @(negedge clk);
    check("t2_single_pulse", 64'(n_pc - pc0), 64'd1);

    // Auto-rotate over pages 0 and 2 (first a forced move off page 1)
    exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0);
    page_en = 3'b101;
    auto_mode = 1'b1;
    t_prev = 0;
    for (int j = 0; j < 6; j++) begin
      wait_change(30, "t3_pulse");
      t_now = cyc;
      if (j > 0) check("t3_spacing", 64'(t_now - t_prev), 64'd12);
      t_prev = t_now;
    end
    auto_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Current page disabled: forced advance, then presses do nothing
    exp_q.push_back(1);
    page_en = 3'b010;
    wait_change(5, "t4_forced");
    repeat (3) @(negedge clk);
    check("t4_led_page1", led_out, p1);
    pc0 = n_pc;
    blank_seen = 1'b0;
    page_btn = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 10) page_btn = 1'b0;
      if (led_out == ALL_OFF) blank_seen = 1'b1;
    end
    check("t4_no_pulse", 64'(n_pc - pc0), 64'd0);
    check("t4_no_blank", 64'(blank_seen), 64'd0);
    check("t4_idx", 64'(page_idx), 64'd1);

    // No page enabled: dark and frozen
    page_en = 3'b000;
    @(negedge clk);
    check("t5_led_off", led_out, ALL_OFF);
    pc0 = n_pc;
    auto_mode = 1'b1;
    page_btn = 1'b1;
    repeat (10) @(negedge clk);
    page_btn = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_no_pulse", 64'(n_pc - pc0), 64'd0);
    check("t5_idx", 64'(page_idx), 64'd1);
    check("t5_led_still_off", led_out, ALL_OFF);
    auto_mode = 1'b0;

    // Reset during BLANK
    page_en = 3'b111;
    exp_q.push_back(2);
    page_btn = 1'b1;
    wait_change(20, "t6_pulse");
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_led", led_out, ALL_OFF);
    check("t6_rst_idx", 64'(page_idx), 64'd0);
    check("t6_rst_pc", 64'(page_change), 64'd0);
    page_btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_show_after_rst", led_out, p0);
    repeat (10) @(negedge clk);

    // Reset during debounce: full re-debounce needed afterwards
    page_btn = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pc0 = n_pc;
    repeat (5) @(negedge clk);
    check("t6_no_early_pulse", 64'(n_pc - pc0), 64'd0);
    exp_q.push_back(1);
    wait_change(10, "t6_redebounce");
    page_btn = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_idx", 64'(page_idx), 64'd1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
